// File: rtl/retire_stage_pkg.sv
// Shared types and sizing for the retire stage: ROB retire packets, free-list
// return packets and the RUN/HALTED state encoding.
package retire_stage_pkg;

  localparam int N               = 3;
  localparam int PHYS_REG_SZ     = 64;
  localparam int ARCH_REG_SZ     = 32;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int PREG_BITS       = $clog2(PHYS_REG_SZ);
  localparam int ARCH_BITS       = $clog2(ARCH_REG_SZ);

  typedef struct packed {
    logic                 complete;
    logic                 halt;
    logic                 mispredict;
    logic [4:0]           dest_reg;
    logic [PREG_BITS-1:0] t;
    logic [PREG_BITS-1:0] t_old;
  } ROB_RETIRE_PACKET;

  typedef struct packed {
    logic                 valid;
    logic [PREG_BITS-1:0] preg;
  } RETIRE_FREE_PACKET;

  localparam logic [0:0] STATE_RUN    = 1'b0;
  localparam logic [0:0] STATE_HALTED = 1'b1;

endpackage

// File: rtl/retire_stage_arch_map_table.sv
// Committed architectural-to-physical map with N write ports; a younger lane
// overrides an older lane writing the same architectural register.
module arch_map_table
  import retire_stage_pkg::*;
(
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N-1:0]                           i_wrEn,
  input  logic [N-1:0][ARCH_BITS-1:0]            i_wrIdx,
  input  logic [N-1:0][PREG_BITS-1:0]            i_wrData,
  output logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0]  o_map
);

  logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0] r_map;

  // Lanes are visited oldest first, so the last non-blocking write (youngest) wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REG_SZ; i++) begin
        r_map[i] <= PREG_BITS'(i);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (i_wrEn[k]) begin
          r_map[i_wrIdx[k]] <= i_wrData[k];
        end
      end
    end
  end

  assign o_map = r_map;

endmodule

// File: rtl/retire_stage.sv
// In-order commit engine: picks how many ROB head entries retire, updates the
// committed map, returns old tags to the free list, and raises flush/halt.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic                                   clock,
  input  logic                                   reset,
  input  ROB_RETIRE_PACKET [N-1:0]               rob_outputs,
  input  logic [N-1:0]                           outputs_valid,
  output logic [NUM_SCALAR_BITS-1:0]             num_retiring,
  output logic [N-1:0]                           free_valid,
  output logic [N-1:0][PREG_BITS-1:0]            free_preg,
  output logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0]  arch_map,
  output logic                                   flush,
  output logic                                   halted,
  output logic [63:0]                            retired_count
);

  logic [0:0]                     r_state;
  RETIRE_FREE_PACKET [N-1:0]      r_free;
  logic                           r_flush;
  logic [63:0]                    r_retiredCount;

  logic [NUM_SCALAR_BITS-1:0]     w_numRetiring;
  logic                           w_stop;
  logic                           w_anyMispredict;
  logic                           w_anyHalt;
  logic [N-1:0]                   w_wrEn;
  logic [N-1:0][ARCH_BITS-1:0]    w_wrIdx;
  logic [N-1:0][PREG_BITS-1:0]    w_wrData;

  // Walk the head in age order; a mispredict or halt retires but ends the group.
  always_comb begin
    w_numRetiring   = '0;
    w_stop          = 1'b0;
    w_anyMispredict = 1'b0;
    w_anyHalt       = 1'b0;
    if (!reset && r_state == STATE_RUN) begin
      for (int i = 0; i < N; i++) begin
        if (!w_stop) begin
          if (outputs_valid[i] && rob_outputs[i].complete) begin
            w_numRetiring = NUM_SCALAR_BITS'(i + 1);
            if (rob_outputs[i].mispredict) w_anyMispredict = 1'b1;
            if (rob_outputs[i].halt)       w_anyHalt       = 1'b1;
            if (rob_outputs[i].mispredict || rob_outputs[i].halt) w_stop = 1'b1;
          end else begin
            w_stop = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_wrEn[k]   = (NUM_SCALAR_BITS'(k) < w_numRetiring) &&
                    (rob_outputs[k].dest_reg != 5'd0);
      w_wrIdx[k]  = ARCH_BITS'(rob_outputs[k].dest_reg);
      w_wrData[k] = rob_outputs[k].t;
    end
  end

  arch_map_table u_archMap (
    .clock    (clock),
    .reset    (reset),
    .i_wrEn   (w_wrEn),
    .i_wrIdx  (w_wrIdx),
    .i_wrData (w_wrData),
    .o_map    (arch_map)
  );

  // Registered side effects of this cycle's retirement group.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= STATE_RUN;
      r_free         <= '0;
      r_flush        <= 1'b0;
      r_retiredCount <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        r_free[k].valid <= w_wrEn[k];
        r_free[k].preg  <= w_wrEn[k] ? rob_outputs[k].t_old : '0;
      end
      r_flush        <= w_anyMispredict;
      r_retiredCount <= r_retiredCount + 64'(w_numRetiring);
      if (w_anyHalt) begin
        r_state <= STATE_HALTED;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      free_valid[k] = r_free[k].valid;
      free_preg[k]  = r_free[k].preg;
    end
  end

  assign num_retiring  = w_numRetiring;
  assign flush         = r_flush;
  assign halted        = (r_state == STATE_HALTED);
  assign retired_count = r_retiredCount;

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops them and compares combinational then registered outputs.
module tb_retire_stage;
  import retire_stage_pkg::*;

  logic                                   clock = 1'b0;
  logic                                   reset = 1'b1;
  ROB_RETIRE_PACKET [N-1:0]               rob_outputs = '0;
  logic [N-1:0]                           outputs_valid = '0;
  logic [NUM_SCALAR_BITS-1:0]             num_retiring;
  logic [N-1:0]                           free_valid;
  logic [N-1:0][PREG_BITS-1:0]            free_preg;
  logic [ARCH_REG_SZ-1:0][PREG_BITS-1:0]  arch_map;
  logic                                   flush;
  logic                                   halted;
  logic [63:0]                            retired_count;

  retire_stage dut (
    .clock         (clock),
    .reset         (reset),
    .rob_outputs   (rob_outputs),
    .outputs_valid (outputs_valid),
    .num_retiring  (num_retiring),
    .free_valid    (free_valid),
    .free_preg     (free_preg),
    .arch_map      (arch_map),
    .flush         (flush),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NUM_SCALAR_BITS-1:0]   expNum;
    logic [N-1:0]                 expFreeValid;
    logic [N-1:0][PREG_BITS-1:0]  expFreePreg;
    logic                         expFlush;
    logic                         expHalted;
    logic [63:0]                  expCount;
    logic [ARCH_BITS-1:0]         idxA;
    logic [PREG_BITS-1:0]         valA;
    logic [ARCH_BITS-1:0]         idxB;
    logic [PREG_BITS-1:0]         valB;
  } expect_t;

  expect_t q[$];
  expect_t pending;
  logic    havePending = 1'b0;
  int      compared   = 0;
  int      mismatched = 0;

  function automatic ROB_RETIRE_PACKET mk(logic c, logic h, logic m, int d, int t, int told);
    ROB_RETIRE_PACKET p;
    p.complete   = c;
    p.halt       = h;
    p.mispredict = m;
    p.dest_reg   = 5'(d);
    p.t          = PREG_BITS'(t);
    p.t_old      = PREG_BITS'(told);
    return p;
  endfunction

  function automatic expect_t mkExp(int num, logic [N-1:0] fv, logic [N-1:0][PREG_BITS-1:0] pr,
                                    logic fl, logic h, logic [63:0] cnt,
                                    int ia, int va, int ib, int vb);
    expect_t e;
    e.expNum       = NUM_SCALAR_BITS'(num);
    e.expFreeValid = fv;
    e.expFreePreg  = pr;
    e.expFlush     = fl;
    e.expHalted    = h;
    e.expCount     = cnt;
    e.idxA         = ARCH_BITS'(ia);
    e.valA         = PREG_BITS'(va);
    e.idxB         = ARCH_BITS'(ib);
    e.valB         = PREG_BITS'(vb);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input ROB_RETIRE_PACKET [N-1:0] pk,
                               input logic [N-1:0] v, input expect_t e);
    @(posedge clock);
    #1;
    reset         = rst;
    rob_outputs   = pk;
    outputs_valid = v;
    q.push_back(e);
  endtask

  // Registered results of the previous record are checked first, then this cycle's num_retiring.
  initial begin
    forever begin
      @(negedge clock);
      if (havePending) begin
        checkOutput("free_valid", 64'(free_valid), 64'(pending.expFreeValid));
        for (int k = 0; k < N; k++) begin
          if (pending.expFreeValid[k]) begin
            checkOutput($sformatf("free_preg[%0d]", k), 64'(free_preg[k]), 64'(pending.expFreePreg[k]));
          end
        end
        checkOutput("flush", 64'(flush), 64'(pending.expFlush));
        checkOutput("halted", 64'(halted), 64'(pending.expHalted));
        checkOutput("retired_count", retired_count, pending.expCount);
        checkOutput($sformatf("arch_map[%0d]", pending.idxA), 64'(arch_map[pending.idxA]), 64'(pending.valA));
        checkOutput($sformatf("arch_map[%0d]", pending.idxB), 64'(arch_map[pending.idxB]), 64'(pending.valB));
        havePending = 1'b0;
      end
      if (q.size() > 0) begin
        pending = q.pop_front();
        checkOutput("num_retiring", 64'(num_retiring), 64'(pending.expNum));
        havePending = 1'b1;
      end
      assert (((outputs_valid + N'(1)) & outputs_valid) == '0)
        else $error("[TB] outputs_valid not contiguous: %b", outputs_valid);
    end
  end

  initial begin
    ROB_RETIRE_PACKET [N-1:0] p;
    int waitCycles;

    p = '0;
    applyStimulus(1'b1, p, 3'b000, mkExp(0, 3'b000, '0, 0, 0, 0, 5, 5, 1, 1));
    applyStimulus(1'b1, p, 3'b000, mkExp(0, 3'b000, '0, 0, 0, 0, 5, 5, 1, 1));

    p[0] = mk(1, 0, 0, 1, 40, 1);
    p[1] = mk(1, 0, 0, 2, 41, 2);
    p[2] = mk(1, 0, 0, 3, 42, 3);
    applyStimulus(1'b0, p, 3'b111, mkExp(3, 3'b111, {6'd3, 6'd2, 6'd1}, 0, 0, 3, 1, 40, 3, 42));

    p[0] = mk(1, 0, 0, 4, 43, 4);
    p[1] = mk(0, 0, 0, 5, 46, 5);
    p[2] = mk(1, 0, 0, 5, 47, 5);
    applyStimulus(1'b0, p, 3'b111, mkExp(1, 3'b001, {6'd0, 6'd0, 6'd4}, 0, 0, 4, 4, 43, 5, 5));

    p[0] = mk(1, 0, 0, 0, 48, 30);
    p[1] = mk(1, 0, 0, 6, 44, 6);
    p[2] = mk(1, 0, 0, 9, 49, 9);
    applyStimulus(1'b0, p, 3'b011, mkExp(2, 3'b010, {6'd0, 6'd6, 6'd0}, 0, 0, 6, 0, 0, 6, 44));

    p[0] = mk(1, 0, 1, 8, 45, 8);
    p[1] = mk(1, 0, 0, 9, 55, 9);
    p[2] = mk(1, 0, 0, 10, 56, 10);
    applyStimulus(1'b0, p, 3'b111, mkExp(1, 3'b001, {6'd0, 6'd0, 6'd8}, 1, 0, 7, 8, 45, 9, 9));
    applyStimulus(1'b0, p, 3'b000, mkExp(0, 3'b000, '0, 0, 0, 7, 8, 45, 1, 40));

    p[0] = mk(1, 0, 0, 7, 50, 7);
    p[1] = mk(1, 0, 0, 11, 51, 11);
    p[2] = mk(1, 0, 0, 7, 52, 20);
    applyStimulus(1'b0, p, 3'b111, mkExp(3, 3'b111, {6'd20, 6'd11, 6'd7}, 0, 0, 10, 7, 52, 11, 51));
    applyStimulus(1'b0, p, 3'b000, mkExp(0, 3'b000, '0, 0, 0, 10, 7, 52, 4, 43));

    p[0] = mk(1, 0, 0, 12, 53, 12);
    p[1] = mk(1, 1, 0, 13, 54, 13);
    p[2] = mk(1, 0, 0, 14, 57, 14);
    applyStimulus(1'b0, p, 3'b111, mkExp(2, 3'b011, {6'd0, 6'd13, 6'd12}, 0, 1, 12, 13, 54, 14, 14));

    p[0] = mk(1, 0, 0, 15, 58, 15);
    p[1] = mk(1, 0, 0, 16, 59, 16);
    p[2] = mk(1, 0, 0, 17, 62, 17);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, p, 3'b111, mkExp(0, 3'b000, '0, 0, 1, 12, 15, 15, 13, 54));
    end
    applyStimulus(1'b1, p, 3'b111, mkExp(0, 3'b000, '0, 0, 0, 0, 13, 13, 7, 7));

    p[0] = mk(1, 1, 1, 2, 60, 2);
    p[1] = mk(1, 0, 0, 3, 61, 3);
    p[2] = mk(1, 0, 0, 4, 63, 4);
    applyStimulus(1'b0, p, 3'b111, mkExp(1, 3'b001, {6'd0, 6'd0, 6'd2}, 1, 1, 1, 2, 60, 3, 3));
    applyStimulus(1'b1, p, 3'b111, mkExp(0, 3'b000, '0, 0, 0, 0, 2, 2, 1, 1));
    applyStimulus(1'b0, p, 3'b000, mkExp(0, 3'b000, '0, 0, 0, 0, 5, 5, 2, 2));

    waitCycles = 0;
    while ((q.size() > 0 || havePending) && waitCycles < 20) begin
      @(posedge clock);
      waitCycles++;
    end
    @(negedge clock);
    #1;
    if (q.size() > 0 || havePending) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d records left, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
